// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared opcodes, field widths and instruction format enum
package instr_pkg;

  localparam int OPCODE_W = 5;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 17;
  localparam int TARG_W   = 27;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_J     = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_JR    = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_BLT   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SW    = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_LW    = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_SETX  = 5'b10101;
  localparam logic [OPCODE_W-1:0] OP_BEX   = 5'b10110;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_JI  = 2'd2,
    FMT_JII = 2'd3
  } fmt_e;

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational field-to-word packer (range flag under INSTR_RANGE_CHECK_EN)
module instr_pack
  import instr_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [REG_W-1:0]    i_rd,
  input  logic [REG_W-1:0]    i_rs,
  input  logic [REG_W-1:0]    i_rt,
  input  logic [REG_W-1:0]    i_shamt,
  input  logic [REG_W-1:0]    i_aluop,
  input  logic [31:0]         i_imm,
  input  logic [31:0]         i_target,
  output logic [31:0]         o_word,
  output fmt_e                o_fmt,
  output logic                o_illegal,
  output logic                o_range_err
);

  // Classify the opcode; unknown opcodes fall back to I-type and are flagged
  always_comb begin
    o_fmt     = FMT_I;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE:                          o_fmt = FMT_R;
      OP_BNE, OP_ADDI, OP_BLT, OP_SW,
      OP_LW:                             o_fmt = FMT_I;
      OP_J, OP_JAL, OP_SETX, OP_BEX:     o_fmt = FMT_JI;
      OP_JR:                             o_fmt = FMT_JII;
      default:                           o_illegal = 1'b1;
    endcase
  end

  // Pack fields into the 32-bit word for the selected format
  always_comb begin
    case (o_fmt)
      FMT_R:   o_word = {i_opcode, i_rd, i_rs, i_rt, i_shamt, i_aluop, 2'b00};
      FMT_JI:  o_word = {i_opcode, i_target[TARG_W-1:0]};
      FMT_JII: o_word = {i_opcode, i_rd, 22'b0};
      default: o_word = {i_opcode, i_rd, i_rs, i_imm[IMM_W-1:0]};
    endcase
  end

`ifdef INSTR_RANGE_CHECK_EN
  logic w_imm_oor;
  logic w_targ_oor;

  // A 17-bit signed immediate fits only when bits 31..16 are all sign copies
  always_comb begin
    w_imm_oor   = !((&i_imm[31:IMM_W-1]) || !(|i_imm[31:IMM_W-1]));
    w_targ_oor  = |i_target[31:TARG_W];
    o_range_err = ((o_fmt == FMT_I) && w_imm_oor) || ((o_fmt == FMT_JI) && w_targ_oor);
  end
`else
  logic w_unused_hi;

  // Upper field bits are truncated silently in this build
  always_comb begin
    o_range_err = 1'b0;
    w_unused_hi = ^{i_imm[31:IMM_W], i_target[31:TARG_W]};
  end
`endif

endmodule

// File: rtl/instr_encode_writer.sv
// rtl/instr_encode_writer.sv - field bundle encoder streaming words into imem (option INSTR_RANGE_CHECK_EN)
module instr_encode_writer
  import instr_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic                i_in_last,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [REG_W-1:0]    i_rd,
  input  logic [REG_W-1:0]    i_rs,
  input  logic [REG_W-1:0]    i_rt,
  input  logic [REG_W-1:0]    i_shamt,
  input  logic [REG_W-1:0]    i_aluop,
  input  logic [31:0]         i_imm,
  input  logic [31:0]         i_target,
  output logic                o_imem_wren,
  output logic [ADDR_W-1:0]   o_imem_addr,
  output logic [31:0]         o_imem_data,
  output logic [ADDR_W:0]     o_word_count,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_addr_cnt;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [31:0]         r_imem_data;
  logic [ADDR_W:0]     r_count;
  logic                r_err;
  logic                r_last;

  logic                w_in_ready;
  logic                w_wren;
  logic                w_busy;
  logic                w_done;
  logic                w_transfer;
  logic [ADDR_W:0]     w_count_inc;
  logic                w_cap_hit;
  logic [31:0]         w_word;
  fmt_e                w_unused_fmt;
  logic                w_illegal;
  logic                w_range_err;

  instr_pack u_pack (
    .i_opcode    (i_opcode),
    .i_rd        (i_rd),
    .i_rs        (i_rs),
    .i_rt        (i_rt),
    .i_shamt     (i_shamt),
    .i_aluop     (i_aluop),
    .i_imm       (i_imm),
    .i_target    (i_target),
    .o_word      (w_word),
    .o_fmt       (w_unused_fmt),
    .o_illegal   (w_illegal),
    .o_range_err (w_range_err)
  );

  assign w_transfer  = w_in_ready && i_in_valid;
  assign w_count_inc = r_count + 1'b1;
  assign w_cap_hit   = (w_count_inc == CAPACITY);

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state handshake/strobe outputs
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_wren       = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = S_ACCEPT;
      end
      S_ACCEPT: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (i_in_valid) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        w_wren = 1'b1;
        w_busy = 1'b1;
        if (r_last || w_cap_hit) w_state_next = S_DONE;
        else                     w_state_next = S_ACCEPT;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_busy       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Session counters, captured word/address and sticky error
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_addr_cnt  <= '0;
      r_imem_addr <= '0;
      r_imem_data <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_addr_cnt <= BASE_ADDR;
        r_count    <= '0;
        r_err      <= 1'b0;
      end
      if (w_transfer) begin
        r_imem_addr <= r_addr_cnt;
        r_imem_data <= w_word;
        r_last      <= i_in_last;
        if (w_illegal || w_range_err) r_err <= 1'b1;
      end
      if (r_state == S_WRITE) begin
        r_addr_cnt <= r_addr_cnt + 1'b1;
        r_count    <= w_count_inc;
        if (w_cap_hit && !r_last) r_err <= 1'b1;
      end
    end
  end

  // A reset arriving during WRITE drops the in-flight word rather than committing it
  assign o_imem_wren  = w_wren && !i_reset;
  assign o_in_ready   = w_in_ready;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_data  = r_imem_data;
  assign o_word_count = r_count;
  assign o_busy       = w_busy;
  assign o_done       = w_done;
  assign o_err        = r_err;

endmodule
